// File: rtl/cfi_lp_csr_pkg.sv
// Shared definitions for the landing-pad CFI unit.
//   lp_op_t      : committed CFI/CSR operation encoding
//   lp_state_t   : expected-landing-pad state
//   LL_W/ML_W/UL_W : label segment widths (LPLR = {UL, ML, LL})
//   LP_CAUSE_*   : CFI exception cause codes
//   CSR_LPLR/CSR_ELP : CSR addresses decoded by the unit
package cfi_lp_csr_pkg;

    localparam int LL_W   = 9;
    localparam int ML_W   = 8;
    localparam int UL_W   = 8;
    localparam int LPLR_W = LL_W + ML_W + UL_W;

    typedef enum logic [2:0] {
        LP_NONE = 3'd0,
        LP_SLL  = 3'd1,
        LP_SML  = 3'd2,
        LP_SUL  = 3'd3,
        LP_CLL  = 3'd4,
        LP_CSRW = 3'd5,
        LP_CSRR = 3'd6
    } lp_op_t;

    typedef enum logic [1:0] {
        NO_LP  = 2'd0,
        LP_EXP = 2'd1,
        FAULT  = 2'd2
    } lp_state_t;

    localparam logic [1:0] LP_CAUSE_MISSING  = 2'd1;
    localparam logic [1:0] LP_CAUSE_MISMATCH = 2'd2;

    localparam logic [11:0] CSR_LPLR = 12'h8c0;
    localparam logic [11:0] CSR_ELP  = 12'h8c1;

endpackage

// File: rtl/cfi_lp_csr_label_reg.sv
// lp_label_reg: segmented landing-pad label register.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   we_ll/we_ml/we_ul   : write one segment from the low bits of wdata
//   we_all              : write the whole register from wdata
//   wdata               : write data, already truncated to register width
//   lplr                : current value {UL, ML, LL}
module lp_label_reg
    import cfi_lp_csr_pkg::*;
#(
    parameter int LL_W = 9
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_ll,
    input  logic                         we_ml,
    input  logic                         we_ul,
    input  logic                         we_all,
    input  logic [LL_W+ML_W+UL_W-1:0]    wdata,
    output logic [LL_W+ML_W+UL_W-1:0]    lplr
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lplr <= '0;
        end else if (we_all) begin
            lplr <= wdata;
        end else begin
            // Segment writes always source from the low bits of wdata.
            if (we_ll) lplr[LL_W-1:0]          <= wdata[LL_W-1:0];
            if (we_ml) lplr[LL_W +: ML_W]      <= wdata[ML_W-1:0];
            if (we_ul) lplr[LL_W+ML_W +: UL_W] <= wdata[UL_W-1:0];
        end
    end

endmodule

// File: rtl/cfi_lp_csr.sv
// cfi_lp_csr: commit-side landing-pad CFI unit.
//   clk_i/rst_i          : clock, synchronous active-high reset
//   flush_i              : pipeline flush, clears a pending fault
//   lp_en_i              : landing-pad enforcement enable
//   csr_valid_i/op/addr/wdata : committed CFI/CSR op
//   instr_commit_i, indirect_jump_i : commit stream information
//   csr_ack_o, csr_rdata_o : op acceptance pulse and combinational read data
//   lplr_o, elp_o        : architectural label register and ELP flag
//   cfi_ex_valid_o/cause_o : registered CFI exception
module cfi_lp_csr
    import cfi_lp_csr_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int LL_W = 9
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       lp_en_i,
    input  logic                       csr_valid_i,
    input  logic [2:0]                 csr_op_i,
    input  logic [11:0]                csr_addr_i,
    input  logic [XLEN-1:0]            csr_wdata_i,
    input  logic                       instr_commit_i,
    input  logic                       indirect_jump_i,
    output logic                       csr_ack_o,
    output logic [XLEN-1:0]            csr_rdata_o,
    output logic [LL_W+ML_W+UL_W-1:0]  lplr_o,
    output logic                       elp_o,
    output logic                       cfi_ex_valid_o,
    output logic [1:0]                 cfi_ex_cause_o
);

    localparam int W = LL_W + ML_W + UL_W;

    lp_state_t  state_q, state_d;
    logic [1:0] cause_q, cause_d;
    lp_op_t     op;
    logic       active, is_cll, ll_match, elp_wr;
    logic [W-1:0] lplr;
    logic       unused_wdata;

    assign op       = lp_op_t'(csr_op_i);
    // Ops are accepted outside FAULT and never while reset is held.
    assign active   = csr_valid_i & (state_q != FAULT) & ~rst_i;
    assign is_cll   = csr_valid_i & (op == LP_CLL);
    // LP_CLL always compares against the registered LL.
    assign ll_match = (csr_wdata_i[LL_W-1:0] == lplr[LL_W-1:0]);
    assign elp_wr   = active & (op == LP_CSRW) & (csr_addr_i == CSR_ELP);
    assign unused_wdata = ^csr_wdata_i[XLEN-1:W];

    lp_label_reg #(.LL_W(LL_W)) u_lplr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_ll  (active & (op == LP_SLL)),
        .we_ml  (active & (op == LP_SML)),
        .we_ul  (active & (op == LP_SUL)),
        .we_all (active & (op == LP_CSRW) & (csr_addr_i == CSR_LPLR)),
        .wdata  (csr_wdata_i[W-1:0]),
        .lplr   (lplr)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            NO_LP: begin
                if (is_cll && !ll_match) begin
                    state_d = FAULT;
                    cause_d = LP_CAUSE_MISMATCH;
                end else if (elp_wr) begin
                    state_d = csr_wdata_i[0] ? LP_EXP : NO_LP;
                end else if (instr_commit_i && indirect_jump_i) begin
                    state_d = LP_EXP;
                end
            end
            LP_EXP: begin
                // The first commit after the jump must be a matching LP_CLL.
                if (instr_commit_i) begin
                    if (is_cll && ll_match) begin
                        state_d = NO_LP;
                    end else begin
                        state_d = FAULT;
                        cause_d = is_cll ? LP_CAUSE_MISMATCH : LP_CAUSE_MISSING;
                    end
                end else if (elp_wr) begin
                    state_d = csr_wdata_i[0] ? LP_EXP : NO_LP;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = NO_LP;
        endcase
        // Flush clears a pending or just-raised fault; ELP otherwise survives.
        if (flush_i && state_d == FAULT) state_d = NO_LP;
        if (!lp_en_i) state_d = NO_LP;
        if (state_d != FAULT) cause_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= NO_LP;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        if (active && op == LP_CSRR) begin
            if (csr_addr_i == CSR_LPLR) csr_rdata_o[W-1:0] = lplr;
            else if (csr_addr_i == CSR_ELP) csr_rdata_o[0] = (state_q == LP_EXP);
        end
    end

    assign csr_ack_o      = active;
    assign lplr_o         = lplr;
    assign elp_o          = (state_q == LP_EXP);
    assign cfi_ex_valid_o = (state_q == FAULT);
    assign cfi_ex_cause_o = cause_q;

endmodule

// File: tb/tb_cfi_lp_csr.sv
module tb_cfi_lp_csr;
    import cfi_lp_csr_pkg::*;

    localparam int S_ACK = 0, S_RDATA = 1, S_LPLR = 2, S_ELP = 3, S_EXV = 4, S_CAUSE = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, lp_en_i, csr_valid_i, instr_commit_i, indirect_jump_i;
    logic [2:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_wdata_i;
    logic        csr_ack_o, elp_o, cfi_ex_valid_o;
    logic [63:0] csr_rdata_o;
    logic [24:0] lplr_o;
    logic [1:0]  cfi_ex_cause_o;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cfi_lp_csr #(.XLEN(64), .LL_W(9)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .lp_en_i         (lp_en_i),
        .csr_valid_i     (csr_valid_i),
        .csr_op_i        (csr_op_i),
        .csr_addr_i      (csr_addr_i),
        .csr_wdata_i     (csr_wdata_i),
        .instr_commit_i  (instr_commit_i),
        .indirect_jump_i (indirect_jump_i),
        .csr_ack_o       (csr_ack_o),
        .csr_rdata_o     (csr_rdata_o),
        .lplr_o          (lplr_o),
        .elp_o           (elp_o),
        .cfi_ex_valid_o  (cfi_ex_valid_o),
        .cfi_ex_cause_o  (cfi_ex_cause_o)
    );

    function automatic logic [63:0] pick(int sig);
        case (sig)
            S_ACK:   return {63'd0, csr_ack_o};
            S_RDATA: return csr_rdata_o;
            S_LPLR:  return {39'd0, lplr_o};
            S_ELP:   return {63'd0, elp_o};
            S_EXV:   return {63'd0, cfi_ex_valid_o};
            default: return {62'd0, cfi_ex_cause_o};
        endcase
    endfunction

    // Monitor: at every falling edge, compare all expectations due this cycle.
    initial begin
        logic [63:0] act;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    act = pick(q[i].sig);
                    n_cmp++;
                    if (act !== q[i].val) begin
                        n_err++;
                        $display("FAIL %s (cyc %0d): got 0x%0h, want 0x%0h",
                                 q[i].name, cyc, act, q[i].val);
                    end
                    q.delete(i);
                end
            end
        end
    end

    // off = 0: sampled this cycle; off = 1: after the next rising edge.
    task automatic ex(input int off, input int sig, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + 1 + off;
        e.sig  = sig;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input lp_op_t op, input logic [11:0] a,
                         input logic [63:0] d, input logic cm, input logic ij);
        csr_valid_i     = v;
        csr_op_i        = op;
        csr_addr_i      = a;
        csr_wdata_i     = d;
        instr_commit_i  = cm;
        indirect_jump_i = ij;
    endtask

    task automatic idle();
        drive(1'b0, LP_NONE, 12'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; lp_en_i = 1'b1;
        idle();
        tick();

        // Reset: ack held low even with a valid op; registers at reset values.
        drive(1'b1, LP_SLL, 12'h0, 64'h1a5, 1'b1, 1'b0);
        ex(0, S_ACK, 0, "ack_in_reset");
        tick();
        ex(0, S_LPLR, 0, "rst_lplr");
        ex(0, S_ELP, 0, "rst_elp");
        ex(0, S_EXV, 0, "rst_exv");
        ex(0, S_CAUSE, 0, "rst_cause");
        tick();

        // LP_SLL writes LL only; ack is a single pulse.
        rst_i = 1'b0;
        drive(1'b1, LP_SLL, 12'h0, 64'hffff_0000_0000_01a5, 1'b1, 1'b0);
        ex(0, S_ACK, 1, "sll_ack");
        ex(1, S_LPLR, 25'h1a5, "sll_lplr");
        tick();
        n_cmp++;
        if (lplr_o !== 25'h1a5) begin
            n_err++;
            $display("FAIL sll_lplr_direct: got 0x%0h", lplr_o);
        end
        idle();
        ex(0, S_ACK, 0, "ack_pulse_once");
        tick();

        // Indirect jump then matching LP_CLL.
        drive(1'b0, LP_NONE, 12'h0, 64'h0, 1'b1, 1'b1);
        ex(1, S_ELP, 1, "jmp_elp_set");
        tick();
        n_cmp++;
        if (elp_o !== 1'b1) begin
            n_err++;
            $display("FAIL jmp_elp_direct: got %0b", elp_o);
        end
        drive(1'b1, LP_CLL, 12'h0, 64'h1a5, 1'b1, 1'b0);
        ex(0, S_ACK, 1, "cll_ack");
        ex(1, S_ELP, 0, "cll_match_elp");
        ex(1, S_EXV, 0, "cll_match_noex");
        tick();
        idle();
        tick();

        // Indirect jump then a plain instruction: missing landing pad.
        drive(1'b0, LP_NONE, 12'h0, 64'h0, 1'b1, 1'b1);
        ex(1, S_ELP, 1, "jmp2_elp_set");
        tick();
        drive(1'b0, LP_NONE, 12'h0, 64'h0, 1'b1, 1'b0);
        ex(1, S_EXV, 1, "missing_exv");
        ex(1, S_CAUSE, LP_CAUSE_MISSING, "missing_cause");
        ex(1, S_ELP, 0, "missing_elp");
        tick();
        drive(1'b1, LP_SUL, 12'h0, 64'hff, 1'b1, 1'b0);
        ex(0, S_ACK, 0, "fault_no_ack");
        ex(1, S_LPLR, 25'h1a5, "fault_no_write");
        ex(1, S_EXV, 1, "fault_hold");
        tick();
        idle();
        flush_i = 1'b1;
        ex(1, S_EXV, 0, "flush_exv");
        ex(1, S_CAUSE, 0, "flush_cause");
        ex(1, S_ELP, 0, "flush_elp");
        tick();
        flush_i = 1'b0;

        // Plain LP_CLL mismatch in NO_LP, enabled then disabled.
        drive(1'b1, LP_CLL, 12'h0, 64'h0ff, 1'b1, 1'b0);
        ex(0, S_ACK, 1, "chk_ack");
        ex(1, S_EXV, 1, "mismatch_exv");
        ex(1, S_CAUSE, LP_CAUSE_MISMATCH, "mismatch_cause");
        tick();
        idle();
        flush_i = 1'b1;
        ex(1, S_EXV, 0, "mismatch_flush");
        tick();
        flush_i = 1'b0;
        lp_en_i = 1'b0;
        drive(1'b1, LP_CLL, 12'h0, 64'h0ff, 1'b1, 1'b0);
        ex(0, S_ACK, 1, "dis_chk_ack");
        ex(1, S_EXV, 0, "dis_no_exv");
        tick();
        drive(1'b1, LP_SML, 12'h0, 64'h7ab, 1'b1, 1'b0);
        ex(1, S_LPLR, 25'h157a5, "dis_sml_lplr");
        tick();
        drive(1'b0, LP_NONE, 12'h0, 64'h0, 1'b1, 1'b1);
        ex(1, S_ELP, 0, "dis_jmp_no_elp");
        tick();
        lp_en_i = 1'b1;

        // CSR write/read of LPLR, unknown address, ELP write/read.
        drive(1'b1, LP_CSRW, CSR_LPLR, 64'hdead_0000_0123_4567, 1'b1, 1'b0);
        ex(0, S_ACK, 1, "csrw_ack");
        ex(1, S_LPLR, 25'h1234567, "csrw_lplr");
        tick();
        n_cmp++;
        if (lplr_o !== 25'h1234567) begin
            n_err++;
            $display("FAIL csrw_lplr_direct: got 0x%0h", lplr_o);
        end
        drive(1'b1, LP_CSRR, CSR_LPLR, 64'h0, 1'b1, 1'b0);
        ex(0, S_RDATA, 64'h1234567, "csrr_lplr");
        tick();
        drive(1'b1, LP_CSRR, 12'h123, 64'h0, 1'b1, 1'b0);
        ex(0, S_ACK, 1, "badaddr_ack");
        ex(0, S_RDATA, 0, "badaddr_rdata");
        tick();
        drive(1'b1, LP_CSRW, CSR_ELP, 64'h1, 1'b1, 1'b0);
        ex(1, S_ELP, 1, "csrw_elp");
        tick();
        drive(1'b1, LP_CSRR, CSR_ELP, 64'h0, 1'b0, 1'b0);
        ex(0, S_RDATA, 1, "csrr_elp");
        tick();
        drive(1'b1, LP_CLL, 12'h0, 64'h167, 1'b1, 1'b0);
        ex(1, S_ELP, 0, "cll_new_ll");
        ex(1, S_EXV, 0, "cll_new_ll_noex");
        tick();

        // Flush preserves ELP; flush beats a same-cycle offending commit.
        drive(1'b0, LP_NONE, 12'h0, 64'h0, 1'b1, 1'b1);
        ex(1, S_ELP, 1, "jmp3_elp");
        tick();
        idle();
        flush_i = 1'b1;
        ex(1, S_ELP, 1, "flush_keeps_elp");
        tick();
        drive(1'b0, LP_NONE, 12'h0, 64'h0, 1'b1, 1'b0);
        ex(1, S_EXV, 0, "flush_wins_exv");
        ex(1, S_CAUSE, 0, "flush_wins_cause");
        ex(1, S_ELP, 0, "flush_wins_elp");
        tick();
        flush_i = 1'b0;

        // Reset during FAULT.
        drive(1'b1, LP_CLL, 12'h0, 64'h0, 1'b1, 1'b0);
        ex(1, S_EXV, 1, "pre_rst_exv");
        ex(1, S_CAUSE, LP_CAUSE_MISMATCH, "pre_rst_cause");
        tick();
        rst_i = 1'b1;
        drive(1'b1, LP_SLL, 12'h0, 64'h55, 1'b1, 1'b0);
        ex(0, S_ACK, 0, "fault_rst_ack");
        ex(1, S_EXV, 0, "rst_fault_exv");
        ex(1, S_CAUSE, 0, "rst_fault_cause");
        ex(1, S_LPLR, 0, "rst_fault_lplr");
        ex(1, S_ELP, 0, "rst_fault_elp");
        tick();
        n_cmp++;
        if (cfi_ex_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fault_exv_direct: got %0b", cfi_ex_valid_o);
        end
        n_cmp++;
        if (cfi_ex_cause_o !== 2'd0) begin
            n_err++;
            $display("FAIL rst_fault_cause_direct: got %0d", cfi_ex_cause_o);
        end
        rst_i = 1'b0;
        idle();
        tick();
        tick();

        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        while (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: never sampled (due cyc %0d)", q[0].name, q[0].cyc);
            q.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
